alu_share_arbiter: RTL

//   Shares one alu_4bit instance among NREQ requesters. Each requester presents an operand pair and an opcode.
//   A round-robin arbiter grants one request at a time. The operands are registered into the ALU and the

---
 rtl/alu_share_arbiter.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one alu_4bit among NREQ requesters.
// Define ALU_ARB_FLAGS_EN to add the registered rsp_zero / rsp_ovf outputs.

module alu_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic [1:0] op,
   output logic [3:0] y,
   output logic       cout
);
   logic [4:0] sum;

   always_comb begin
      sum  = 5'd0;
      y    = 4'd0;
      cout = 1'b0;
      case (op)
         2'b00: begin
            sum  = {1'b0, a} + {1'b0, b};
            y    = sum[3:0];
            cout = sum[4];
         end
         2'b01: begin
            sum  = {1'b0, a} + {1'b0, ~b} + 5'd1;
            y    = sum[3:0];
            cout = sum[4];
         end
         2'b10: y = a & b;
         default: y = a | b;
      endcase
   end
endmodule

module alu_share_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   input  logic [2*NREQ-1:0] req_op,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [IDW-1:0]    rsp_id,
   output logic [3:0]        rsp_result,
   output logic              rsp_cout
`ifdef ALU_ARB_FLAGS_EN
   ,
   output logic              rsp_zero,
   output logic              rsp_ovf
`endif
);
   if (NREQ < 2 || NREQ > 4) begin : g_bad_nreq
      $error("alu_share_arbiter: NREQ must be in 2..4");
   end
   if (IDW != ((NREQ > 2) ? 2 : 1)) begin : g_bad_idw
      $error("alu_share_arbiter: IDW must be max(1,clog2(NREQ))");
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
   logic [3:0]     a_q, a_d;
   logic [3:0]     b_q, b_d;
   logic [1:0]     op_q, op_d;
   logic [IDW-1:0] tag_q, tag_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0] rsp_id_q, rsp_id_d;
   logic [3:0]     rsp_result_q, rsp_result_d;
   logic           rsp_cout_q, rsp_cout_d;
`ifdef ALU_ARB_FLAGS_EN
   logic           rsp_zero_q, rsp_zero_d;
   logic           rsp_ovf_q, rsp_ovf_d;
   logic           ovf;
`endif

   logic [IDW:0]   cand;
   logic [IDW-1:0] gnt_idx;
   logic           gnt_found;
   logic [3:0]     sel_a;
   logic [3:0]     sel_b;
   logic [1:0]     sel_op;
   logic [3:0]     alu_y;
   logic           alu_cout;

   // Walk from the lowest priority slot up so the first hit wins last.
   always_comb begin
      cand      = '0;
      gnt_idx   = '0;
      gnt_found = 1'b0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
         if (cand >= (IDW+1)'(NREQ)) begin
            cand = cand - (IDW+1)'(NREQ);
         end
         if (req_valid[cand[IDW-1:0]]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand[IDW-1:0];
         end
      end
   end

   always_comb begin
      sel_a  = '0;
      sel_b  = '0;
      sel_op = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt_idx == IDW'(i)) begin
            sel_a  = req_a[4*i +: 4];
            sel_b  = req_b[4*i +: 4];
            sel_op = req_op[2*i +: 2];
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == IDLE && gnt_found && !rst) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   alu_4bit u_alu (
      .a    (a_q),
      .b    (b_q),
      .op   (op_q),
      .y    (alu_y),
      .cout (alu_cout)
   );

`ifdef ALU_ARB_FLAGS_EN
   always_comb begin
      ovf = 1'b0;
      if (op_q == 2'b00) begin
         ovf = (a_q[3] == b_q[3]) && (alu_y[3] != a_q[3]);
      end else if (op_q == 2'b01) begin
         ovf = (a_q[3] != b_q[3]) && (alu_y[3] != a_q[3]);
      end
   end
`endif

   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      a_d          = a_q;
      b_d          = b_q;
      op_d         = op_q;
      tag_d        = tag_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_result_d = rsp_result_q;
      rsp_cout_d   = rsp_cout_q;
`ifdef ALU_ARB_FLAGS_EN
      rsp_zero_d   = rsp_zero_q;
      rsp_ovf_d    = rsp_ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (gnt_found) begin
               a_d      = sel_a;
               b_d      = sel_b;
               op_d     = sel_op;
               tag_d    = gnt_idx;
               rr_ptr_d = (gnt_idx == IDW'(NREQ - 1)) ?
                          '0 : gnt_idx + IDW'(1);
               state_d  = EXEC;
            end
         end
         EXEC: begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = tag_q;
            rsp_result_d = alu_y;
            // Logic ops have no meaningful carry.
            rsp_cout_d   = op_q[1] ? 1'b0 : alu_cout;
`ifdef ALU_ARB_FLAGS_EN
            rsp_zero_d   = (alu_y == 4'd0);
            rsp_ovf_d    = ovf;
`endif
            state_d      = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         a_q          <= '0;
         b_q          <= '0;
         op_q         <= '0;
         tag_q        <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_result_q <= '0;
         rsp_cout_q   <= 1'b0;
`ifdef ALU_ARB_FLAGS_EN
         rsp_zero_q   <= 1'b0;
         rsp_ovf_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         a_q          <= a_d;
         b_q          <= b_d;
         op_q         <= op_d;
         tag_q        <= tag_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_result_q <= rsp_result_d;
         rsp_cout_q   <= rsp_cout_d;
`ifdef ALU_ARB_FLAGS_EN
         rsp_zero_q   <= rsp_zero_d;
         rsp_ovf_q    <= rsp_ovf_d;
`endif
      end
   end

   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = rsp_id_q;
   assign rsp_result = rsp_result_q;
   assign rsp_cout   = rsp_cout_q;
`ifdef ALU_ARB_FLAGS_EN
   assign rsp_zero   = rsp_zero_q;
   assign rsp_ovf    = rsp_ovf_q;
`endif
endmodule
